// File: rtl/shot_turn_sequencer_if.sv
// Control/status bundle between the game logic and the shot/turn sequencer.
interface shot_turn_sequencer_if #(
  parameter int unsigned NUM_BALLS = 16
) ();
  logic                 startOfFrame;
  logic                 shootKey;
  logic [2:0]           aimDir;
  logic [NUM_BALLS-1:0] ballsMoving;
  logic                 ballPocketed;
  logic                 whitePocketed;
  logic                 chargeWhiteBall;
  logic signed [10:0]   WhiteBall_Xspeed_Charge;
  logic signed [10:0]   WhiteBall_Yspeed_Charge;
  logic [9:0]           shotPower;
  logic [2:0]           state;
  logic                 turnPlayer;
  logic                 respotWhite;
  logic                 forceStop;
  logic [7:0]           shotCount;

  modport master (
    output startOfFrame, shootKey, aimDir, ballsMoving, ballPocketed, whitePocketed,
    input  chargeWhiteBall, WhiteBall_Xspeed_Charge, WhiteBall_Yspeed_Charge, shotPower,
    input  state, turnPlayer, respotWhite, forceStop, shotCount
  );

  modport slave (
    input  startOfFrame, shootKey, aimDir, ballsMoving, ballPocketed, whitePocketed,
    output chargeWhiteBall, WhiteBall_Xspeed_Charge, WhiteBall_Yspeed_Charge, shotPower,
    output state, turnPlayer, respotWhite, forceStop, shotCount
  );
endinterface

// File: rtl/shot_turn_sequencer.sv
// Shot/turn sequencer: aim, charge power, fire the white ball, wait for the table
// to settle (or time out) and decide whose turn is next.
module shot_turn_sequencer #(
  parameter int unsigned NUM_BALLS       = 16,
  parameter int unsigned MAX_SHOT_SPEED  = 512,
  parameter int unsigned SPEED_STEP      = 64,
  parameter int unsigned SETTLE_FRAMES   = 8,
  parameter int unsigned MAX_ROLL_FRAMES = 1023
) (
  input  logic                  clk,
  input  logic                  resetN,
  shot_turn_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StAim     = 3'd0,
    StCharge  = 3'd1,
    StFire    = 3'd2,
    StRolling = 3'd3,
    StTurnEnd = 3'd4
  } state_e;

  localparam int unsigned SettleW   = $clog2(SETTLE_FRAMES + 1);
  localparam int unsigned FrameW    = $clog2(MAX_ROLL_FRAMES + 1);
  localparam logic [10:0] MaxPower  = 11'(MAX_SHOT_SPEED);
  localparam logic [10:0] StepPower = 11'(SPEED_STEP);

  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic [9:0]           power_q, power_d;
  logic [2:0]           dir_q, dir_d;
  logic [SettleW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [FrameW-1:0]    frame_cnt_q, frame_cnt_d;
  logic                 pot_hit_q, pot_hit_d;
  logic                 white_hit_q, white_hit_d;
  logic                 turn_player_q, turn_player_d;
  logic [7:0]           shot_count_q, shot_count_d;
  logic                 force_stop_q, force_stop_d;

  logic [NUM_BALLS-1:0] balls_moving;
  logic                 pot_any, white_any;
  logic [SettleW-1:0]   settle_inc;
  logic [FrameW-1:0]    frame_inc;
  logic [10:0]          power_sum;

  assign balls_moving = bus.ballsMoving;
  // Pulses arriving in the decision cycle itself still count for this turn.
  assign pot_any      = pot_hit_q | bus.ballPocketed;
  assign white_any    = white_hit_q | bus.whitePocketed;
  assign settle_inc   = settle_cnt_q + SettleW'(1);
  assign frame_inc    = frame_cnt_q + FrameW'(1);
  assign power_sum    = {1'b0, power_q} + StepPower;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StAim;
      armed_q       <= 1'b0;
      power_q       <= '0;
      dir_q         <= '0;
      settle_cnt_q  <= '0;
      frame_cnt_q   <= '0;
      pot_hit_q     <= 1'b0;
      white_hit_q   <= 1'b0;
      turn_player_q <= 1'b0;
      shot_count_q  <= '0;
      force_stop_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      power_q       <= power_d;
      dir_q         <= dir_d;
      settle_cnt_q  <= settle_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      pot_hit_q     <= pot_hit_d;
      white_hit_q   <= white_hit_d;
      turn_player_q <= turn_player_d;
      shot_count_q  <= shot_count_d;
      force_stop_q  <= force_stop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    power_d       = power_q;
    dir_d         = dir_q;
    settle_cnt_d  = settle_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    pot_hit_d     = pot_hit_q;
    white_hit_d   = white_hit_q;
    turn_player_d = turn_player_q;
    shot_count_d  = shot_count_q;
    force_stop_d  = 1'b0;

    unique case (state_q)
      StAim: begin
        power_d = '0;
        dir_d   = bus.aimDir;
        if (!bus.shootKey) armed_d = 1'b1;
        if (armed_q && bus.startOfFrame && bus.shootKey) begin
          state_d = StCharge;
          power_d = StepPower[9:0];
        end
      end
      StCharge: begin
        if (!bus.shootKey) begin
          state_d = StFire;
        end else if (bus.startOfFrame) begin
          power_d = (power_sum > MaxPower) ? MaxPower[9:0] : power_sum[9:0];
        end
      end
      StFire: begin
        pot_hit_d    = pot_any;
        white_hit_d  = white_any;
        settle_cnt_d = '0;
        frame_cnt_d  = '0;
        state_d      = StRolling;
      end
      StRolling: begin
        pot_hit_d   = pot_any;
        white_hit_d = white_any;
        if (bus.startOfFrame) begin
          frame_cnt_d  = frame_inc;
          settle_cnt_d = (balls_moving == '0) ? settle_inc : '0;
          if (frame_inc == FrameW'(MAX_ROLL_FRAMES)) begin
            force_stop_d = 1'b1;
            state_d      = StTurnEnd;
          end else if ((balls_moving == '0) && (settle_inc == SettleW'(SETTLE_FRAMES))) begin
            state_d = StTurnEnd;
          end
        end
      end
      StTurnEnd: begin
        if (shot_count_q != 8'hFF) shot_count_d = shot_count_q + 8'd1;
        if (!pot_any || white_any) turn_player_d = ~turn_player_q;
        state_d     = StAim;
        armed_d     = 1'b0;
        power_d     = '0;
        pot_hit_d   = 1'b0;
        white_hit_d = 1'b0;
      end
      default: state_d = StAim;
    endcase
  end

  logic               charge_strobe;
  logic               respot;
  logic signed [10:0] x_speed, y_speed;
  logic signed [10:0] p_s, d_s;
  logic [9:0]         diag_mag;

  always_comb begin
    charge_strobe = (state_q == StFire);
    respot        = (state_q == StTurnEnd) && white_any;
    diag_mag      = power_q - {2'b00, power_q[9:2]};
    p_s           = signed'({1'b0, power_q});
    d_s           = signed'({1'b0, diag_mag});
    x_speed       = '0;
    y_speed       = '0;
    // Screen Y grows downward, so "up" directions carry negative Y.
    if (charge_strobe) begin
      unique case (dir_q)
        3'd0: begin x_speed =  p_s;  y_speed = '0;   end
        3'd1: begin x_speed =  d_s;  y_speed = -d_s; end
        3'd2: begin x_speed = '0;    y_speed = -p_s; end
        3'd3: begin x_speed = -d_s;  y_speed = -d_s; end
        3'd4: begin x_speed = -p_s;  y_speed = '0;   end
        3'd5: begin x_speed = -d_s;  y_speed =  d_s; end
        3'd6: begin x_speed = '0;    y_speed =  p_s; end
        3'd7: begin x_speed =  d_s;  y_speed =  d_s; end
        default: begin x_speed = '0; y_speed = '0; end
      endcase
    end
  end

  assign bus.chargeWhiteBall         = charge_strobe;
  assign bus.WhiteBall_Xspeed_Charge = x_speed;
  assign bus.WhiteBall_Yspeed_Charge = y_speed;
  assign bus.shotPower               = power_q;
  assign bus.state                   = state_q;
  assign bus.turnPlayer              = turn_player_q;
  assign bus.respotWhite             = respot;
  assign bus.forceStop               = force_stop_q;
  assign bus.shotCount               = shot_count_q;

endmodule

// File: tb/tb_shot_turn_sequencer.sv
// Directed bench for shot_turn_sequencer: charge, fire, settle, scratch, timeout, reset abort.
module tb_shot_turn_sequencer;

  logic clk;
  logic resetN;
  int   n_tests;
  int   n_fail;
  int   launches;
  int   respots;
  int   force_stops;

  shot_turn_sequencer_if #(.NUM_BALLS(16)) bus ();

  shot_turn_sequencer #(
    .NUM_BALLS       (16),
    .MAX_SHOT_SPEED  (512),
    .SPEED_STEP      (64),
    .SETTLE_FRAMES   (8),
    .MAX_ROLL_FRAMES (1023)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the rising edge.
  always @(negedge clk or negedge resetN) begin
    if (!resetN) begin
      force_stops <= force_stops;
    end else begin
      if (bus.chargeWhiteBall) launches    <= launches + 1;
      if (bus.respotWhite)     respots     <= respots + 1;
      if (bus.forceStop)       force_stops <= force_stops + 1;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  // Arms in AIM, holds the key for n frames, releases; returns in the FIRE cycle.
  task automatic shoot(input logic [2:0] dir, input int n);
    bus.aimDir   = dir;
    bus.shootKey = 1'b0;
    tick();
    bus.shootKey = 1'b1;
    for (int i = 0; i < n; i++) frame();
    bus.shootKey = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; launches = 0; respots = 0; force_stops = 0;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0; bus.shootKey = 1'b0; bus.aimDir = 3'd0;
    bus.ballsMoving = '0; bus.ballPocketed = 1'b0; bus.whitePocketed = 1'b0;
    tick(); tick();
    chk("rst_state", bus.state, 0);
    chk("rst_power", bus.shotPower, 0);
    chk("rst_count", bus.shotCount, 0);
    chk("rst_turn", bus.turnPlayer, 0);
    chk("rst_strobe", bus.chargeWhiteBall, 0);
    chk("rst_x", bus.WhiteBall_Xspeed_Charge, 0);
    resetN = 1'b1;
    tick();

    // Charge saturation, direction 0
    bus.aimDir = 3'd0;
    tick();
    bus.shootKey = 1'b1;
    frame();
    chk("chg_enter_state", bus.state, 1);
    chk("chg_enter_power", bus.shotPower, 64);
    for (int i = 0; i < 9; i++) frame();
    chk("chg_sat_power", bus.shotPower, 512);
    bus.shootKey = 1'b0;
    tick();
    chk("fire0_state", bus.state, 2);
    chk("fire0_strobe", bus.chargeWhiteBall, 1);
    chk("fire0_x", bus.WhiteBall_Xspeed_Charge, 512);
    chk("fire0_y", bus.WhiteBall_Yspeed_Charge, 0);
    tick();
    chk("roll0_state", bus.state, 3);
    chk("roll0_x", bus.WhiteBall_Xspeed_Charge, 0);
    for (int i = 0; i < 8; i++) frame();
    chk("a_state", bus.state, 0);
    chk("a_count", bus.shotCount, 1);
    chk("a_turn", bus.turnPlayer, 1);
    chk("a_launches", launches, 1);

    // Diagonal shot, then settle after motion
    shoot(3'd3, 3);
    chk("fire3_x", bus.WhiteBall_Xspeed_Charge, -144);
    chk("fire3_y", bus.WhiteBall_Yspeed_Charge, -144);
    tick();
    chk("after3_x", bus.WhiteBall_Xspeed_Charge, 0);
    chk("after3_y", bus.WhiteBall_Yspeed_Charge, 0);
    bus.ballsMoving = 16'h0005;
    for (int i = 0; i < 5; i++) frame();
    chk("moving_state", bus.state, 3);
    bus.ballsMoving = '0;
    for (int i = 0; i < 7; i++) frame();
    chk("quiet7_state", bus.state, 3);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    chk("quiet8_state", bus.state, 4);
    tick();
    chk("b_state", bus.state, 0);
    chk("b_turn", bus.turnPlayer, 0);
    chk("b_count", bus.shotCount, 2);
    chk("b_launches", launches, 2);

    // Scratch: both pockets during ROLLING
    shoot(3'd6, 1);
    chk("fire6_x", bus.WhiteBall_Xspeed_Charge, 0);
    chk("fire6_y", bus.WhiteBall_Yspeed_Charge, 64);
    tick();
    bus.ballPocketed = 1'b1; bus.whitePocketed = 1'b1;
    tick();
    bus.ballPocketed = 1'b0; bus.whitePocketed = 1'b0;
    for (int i = 0; i < 8; i++) frame();
    chk("scr_respots", respots, 1);
    chk("scr_turn", bus.turnPlayer, 1);
    chk("scr_count", bus.shotCount, 3);

    // Object ball only: same player continues
    shoot(3'd2, 1);
    chk("fire2_y", bus.WhiteBall_Yspeed_Charge, -64);
    tick();
    bus.ballPocketed = 1'b1;
    tick();
    bus.ballPocketed = 1'b0;
    for (int i = 0; i < 8; i++) frame();
    chk("pot_turn", bus.turnPlayer, 1);
    chk("pot_respots", respots, 1);

    // Pocket pulse landing in the decision cycle itself
    shoot(3'd1, 2);
    chk("fire1_x", bus.WhiteBall_Xspeed_Charge, 96);
    chk("fire1_y", bus.WhiteBall_Yspeed_Charge, -96);
    tick();
    for (int i = 0; i < 7; i++) frame();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    bus.ballPocketed = 1'b1;
    chk("te_state", bus.state, 4);
    tick();
    bus.ballPocketed = 1'b0;
    chk("te_pot_turn", bus.turnPlayer, 1);
    chk("te_count", bus.shotCount, 5);

    // Timeout with key held across the turn boundary
    shoot(3'd7, 1);
    chk("fire7_x", bus.WhiteBall_Xspeed_Charge, 48);
    chk("fire7_y", bus.WhiteBall_Yspeed_Charge, 48);
    tick();
    bus.ballsMoving = 16'h8000;
    for (int i = 0; i < 1022; i++) frame();
    chk("to_pre_state", bus.state, 3);
    chk("to_pre_force", force_stops, 0);
    bus.shootKey = 1'b1;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    chk("to_state", bus.state, 4);
    chk("to_force", bus.forceStop, 1);
    tick();
    chk("to_aim", bus.state, 0);
    chk("to_force_cnt", force_stops, 1);
    chk("to_turn", bus.turnPlayer, 0);
    chk("to_count", bus.shotCount, 6);
    bus.ballsMoving = '0;
    for (int i = 0; i < 3; i++) frame();
    chk("held_no_charge", bus.state, 0);
    bus.shootKey = 1'b0;
    tick();
    bus.shootKey = 1'b1;
    frame();
    chk("rearm_state", bus.state, 1);
    chk("rearm_power", bus.shotPower, 64);

    // Reset while charging
    frame();
    chk("pre_rst_power", bus.shotPower, 128);
    #2 resetN = 1'b0;
    #1;
    chk("abort_state", bus.state, 0);
    chk("abort_power", bus.shotPower, 0);
    chk("abort_count", bus.shotCount, 0);
    bus.shootKey = 1'b0;
    tick(); tick(); tick();
    chk("abort_launches", launches, 6);
    chk("abort_strobe", bus.chargeWhiteBall, 0);
    resetN = 1'b1;
    tick();
    chk("post_rst_state", bus.state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
